// File: rtl/bht_resolve.sv
// Branch resolution and BHT allocation: carries IF predictions through ID/EX,
// resolves them against the real outcome, and picks the row to (re)write.

module bht_resolve_row (
  input  logic [15:0] count,
  output logic        invalid,
  output logic [14:0] age
);
  assign invalid = count[15];
  assign age     = count[14:0];
endmodule

module bht_resolve #(
  parameter int ROWS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 IF_pred_jump,
  input  logic [31:0]          IF_pred_target,
  input  logic [31:0]          EX_PC,
  input  logic                 EX_Branch,
  input  logic                 Branch_Success,
  input  logic [31:0]          EX_target,
  input  logic [ROWS-1:0]      row_ex_hit,
  input  logic [16*ROWS-1:0]   row_count,
  output logic [ROWS-1:0]      WriteRow,
  output logic [31:0]          write_data,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic [15:0]          branch_cnt,
  output logic [15:0]          mispred_cnt
);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } meta_t;

  meta_t id_meta, ex_meta;

  logic [ROWS-1:0]       row_inv;
  logic [ROWS-1:0][14:0] row_age;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    bht_resolve_row u_row (
      .count   (row_count[16*i +: 16]),
      .invalid (row_inv[i]),
      .age     (row_age[i])
    );
  end

  // Lowest-index priority picks for hit and invalid rows.
  logic [ROWS-1:0] hit_oh, inv_oh;
  logic            hit_found, inv_found;
  always_comb begin
    hit_oh    = '0;
    inv_oh    = '0;
    hit_found = 1'b0;
    inv_found = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_ex_hit[i] && !hit_found) begin
        hit_oh[i] = 1'b1;
        hit_found = 1'b1;
      end
      if (row_inv[i] && !inv_found) begin
        inv_oh[i] = 1'b1;
        inv_found = 1'b1;
      end
    end
  end

  // Oldest row; strict compare keeps the lowest index on a tie.
  logic [14:0]     best_age;
  logic [IW-1:0]   best_idx;
  logic [ROWS-1:0] lru_oh, victim_oh;
  always_comb begin
    best_age = row_age[0];
    best_idx = '0;
    for (int i = 1; i < ROWS; i++) begin
      if (row_age[i] > best_age) begin
        best_age = row_age[i];
        best_idx = IW'(i);
      end
    end
    lru_oh    = ROWS'(1) << best_idx;
    victim_oh = inv_found ? inv_oh : lru_oh;
  end

  logic        pred_taken, tgt_match, mis;
  logic [31:0] pc_plus4, rd;
  assign pred_taken = ex_meta.valid & ex_meta.taken;
  assign tgt_match  = ex_meta.target == EX_target;
  assign pc_plus4   = EX_PC + 32'd4;

  always_comb begin
    mis = 1'b0;
    rd  = '0;
    if (EX_Branch) begin
      if (pred_taken && Branch_Success && !tgt_match) begin
        mis = 1'b1;
        rd  = EX_target;
      end else if (pred_taken && !Branch_Success) begin
        mis = 1'b1;
        rd  = pc_plus4;
      end else if (!pred_taken && Branch_Success) begin
        mis = 1'b1;
        rd  = EX_target;
      end
    end else if (pred_taken) begin
      mis = 1'b1;
      rd  = pc_plus4;
    end
  end

  // A hitting row is rewritten unless it just delivered the right target.
  logic [ROWS-1:0] alloc_wr;
  always_comb begin
    alloc_wr = '0;
    if (EX_Branch && Branch_Success) begin
      if (|row_ex_hit) begin
        if (!(pred_taken && tgt_match))
          alloc_wr = hit_oh;
      end else begin
        alloc_wr = victim_oh;
      end
    end
  end

  assign flush       = !rst && mis;
  assign redirect_pc = rst ? '0 : rd;
  assign WriteRow    = rst ? '0 : alloc_wr;
  assign write_data  = EX_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_meta     <= '0;
      ex_meta     <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (flush) begin
        id_meta <= '0;
        ex_meta <= '0;
      end else if (stall) begin
        ex_meta <= '0;
      end else begin
        ex_meta <= id_meta;
        id_meta <= {1'b1, IF_pred_jump, IF_pred_target};
      end
      if (EX_Branch && branch_cnt != 16'hFFFF)
        branch_cnt <= branch_cnt + 16'd1;
      if (flush && mispred_cnt != 16'hFFFF)
        mispred_cnt <= mispred_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_bht_resolve.sv
// Scoreboard bench for bht_resolve: each driven EX cycle queues its expected
// outputs, which are popped and compared on the following falling edge.

module tb_bht_resolve;
  logic         clk = 1'b0;
  logic         rst, stall, IF_pred_jump, EX_Branch, Branch_Success;
  logic [31:0]  IF_pred_target, EX_PC, EX_target;
  logic [7:0]   row_ex_hit;
  logic [127:0] row_count;
  logic [7:0]   WriteRow;
  logic [31:0]  write_data, redirect_pc;
  logic         flush;
  logic [15:0]  branch_cnt, mispred_cnt;

  bht_resolve #(.ROWS(8)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .IF_pred_jump(IF_pred_jump), .IF_pred_target(IF_pred_target),
    .EX_PC(EX_PC), .EX_Branch(EX_Branch), .Branch_Success(Branch_Success),
    .EX_target(EX_target), .row_ex_hit(row_ex_hit), .row_count(row_count),
    .WriteRow(WriteRow), .write_data(write_data), .flush(flush),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        br;
    logic        fl;
    logic [31:0] rd;
    logic [7:0]  wr;
    logic [31:0] tg;
  } ent_t;

  ent_t        sb[$];
  ent_t        e;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] m_br = '0;
  logic [15:0] m_mp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("flush", {31'd0, flush}, {31'd0, e.fl});
      chk("writerow", {24'd0, WriteRow}, {24'd0, e.wr});
      if (e.fl || e.rst) chk("redirect", redirect_pc, e.rd);
      chk("wdata", write_data, e.tg);
      chk("branch_cnt", {16'd0, branch_cnt}, {16'd0, m_br});
      chk("mispred_cnt", {16'd0, mispred_cnt}, {16'd0, m_mp});
      if (e.rst) begin
        m_br = '0;
        m_mp = '0;
      end else begin
        if (e.br && m_br != 16'hFFFF) m_br = m_br + 16'd1;
        if (e.fl && m_mp != 16'hFFFF) m_mp = m_mp + 16'd1;
      end
    end
  end

  task automatic cyc(input logic efl, input logic [31:0] erd, input logic [7:0] ewr);
    ent_t n;
    n.rst = rst; n.br = EX_Branch; n.fl = efl; n.rd = erd; n.wr = ewr; n.tg = EX_target;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic pj, input logic [31:0] pt);
    IF_pred_jump   = pj;
    IF_pred_target = pt;
  endtask

  task automatic set_ex(input logic br, input logic bs, input logic [31:0] pc,
                        input logic [31:0] tg, input logic [7:0] hit);
    EX_Branch = br; Branch_Success = bs; EX_PC = pc; EX_target = tg; row_ex_hit = hit;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic set_cnt(input int i, input logic [15:0] v);
    row_count[16*i +: 16] = v;
  endtask

  task automatic all_invalid();
    for (int i = 0; i < 8; i++) set_cnt(i, 16'h8000);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    set_if(1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 32'h40, 32'h80, 8'h00);
    all_invalid();
    @(posedge clk); #1;
    // Outputs forced quiet in reset even with a would-be flush on the inputs
    cyc(1'b0, 32'h0, 8'h00);
    rst = 1'b0;

    // Cold BHT: taken branch, no prediction, row 0 is the lowest invalid
    cyc(1'b1, 32'h80, 8'b0000_0001);

    // Correct taken prediction with matching hit
    set_if(1'b1, 32'h80); idle(); cyc(1'b0, 32'h0, 8'h00);
    set_if(1'b0, 32'h0);  cyc(1'b0, 32'h0, 8'h00);
    set_ex(1'b1, 1'b1, 32'h200, 32'h80, 8'b0000_0100); cyc(1'b0, 32'h0, 8'h00);

    // Predicted taken, actually not taken; next cycle must not alias-flush
    set_if(1'b1, 32'h200); idle(); cyc(1'b0, 32'h0, 8'h00);
    set_if(1'b1, 32'h999); cyc(1'b0, 32'h0, 8'h00);
    set_if(1'b0, 32'h0);
    set_ex(1'b1, 1'b0, 32'h100, 32'h200, 8'h00); cyc(1'b1, 32'h104, 8'h00);
    idle(); cyc(1'b0, 32'h0, 8'h00);

    // All rows valid: largest count, lowest index on tie
    set_cnt(0, 16'd3); set_cnt(1, 16'd9); set_cnt(2, 16'd9); set_cnt(3, 16'd1);
    set_cnt(4, 16'd0); set_cnt(5, 16'd0); set_cnt(6, 16'd0); set_cnt(7, 16'd2);
    set_ex(1'b1, 1'b1, 32'h400, 32'h440, 8'h00); cyc(1'b1, 32'h440, 8'b0000_0010);

    // Predicted target wrong on a multi-hit: lowest hit row rewritten
    set_if(1'b1, 32'h80); idle(); cyc(1'b0, 32'h0, 8'h00);
    set_if(1'b0, 32'h0);  cyc(1'b0, 32'h0, 8'h00);
    set_ex(1'b1, 1'b1, 32'h500, 32'h90, 8'b0000_0110); cyc(1'b1, 32'h90, 8'b0000_0010);

    // Alias hit on a non-branch, PC+4 wraps to zero
    set_if(1'b1, 32'h10); idle(); cyc(1'b0, 32'h0, 8'h00);
    set_if(1'b0, 32'h0);  cyc(1'b0, 32'h0, 8'h00);
    set_ex(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h1234, 8'h00); cyc(1'b1, 32'h0, 8'h00);

    // Only row 5 invalid among old rows
    for (int i = 0; i < 8; i++) set_cnt(i, 16'(100 + i));
    set_cnt(5, 16'h8000);
    set_ex(1'b1, 1'b1, 32'h600, 32'h700, 8'h00); cyc(1'b1, 32'h700, 8'b0010_0000);
    // Not predicted, not taken: correct, no write
    set_ex(1'b1, 1'b0, 32'h604, 32'h700, 8'h00); cyc(1'b0, 32'h0, 8'h00);

    // Stall for two cycles: prediction held in ID, bubbles into EX
    set_if(1'b1, 32'h300); idle(); cyc(1'b0, 32'h0, 8'h00);
    stall = 1'b1; set_if(1'b0, 32'h0); cyc(1'b0, 32'h0, 8'h00);
    cyc(1'b0, 32'h0, 8'h00);
    stall = 1'b0; cyc(1'b0, 32'h0, 8'h00);
    set_ex(1'b1, 1'b1, 32'h2F0, 32'h300, 8'b1000_0000); cyc(1'b0, 32'h0, 8'h00);

    // Flush together with stall: both metadata registers must clear
    all_invalid();
    set_if(1'b1, 32'h500); idle(); cyc(1'b0, 32'h0, 8'h00);
    stall = 1'b1; set_if(1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 32'h10, 32'h20, 8'h00); cyc(1'b1, 32'h20, 8'b0000_0001);
    stall = 1'b0; idle(); cyc(1'b0, 32'h0, 8'h00);
    cyc(1'b0, 32'h0, 8'h00);

    // Counter saturation, then reset clears them
    set_ex(1'b1, 1'b1, 32'h40, 32'h80, 8'h00);
    for (int i = 0; i < 65540; i++) cyc(1'b1, 32'h80, 8'b0000_0001);
    rst = 1'b1; cyc(1'b0, 32'h0, 8'h00);
    rst = 1'b0; idle(); cyc(1'b0, 32'h0, 8'h00);
    cyc(1'b0, 32'h0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
